// File: rtl/load_store_unit.sv
// Load/store unit between the integer datapath and a big-endian byte memory.
// Optional range check on requests is enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        dm_cs_o,
  output logic        dm_rd_o,
  output logic        dm_wr_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_din_o,
  input  logic [31:0] dm_dout_i
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q, err_d;
  logic [31:0] mergeWord_q;
  logic [31:0] rdata_q;

  logic        reqErr;
  logic        outOfRange;
  logic [1:0]  lastOffset;
  logic [32:0] lastByte;
  logic [31:0] loadValue;
  logic [31:0] mergedWord;

  // Byte lanes are big-endian: offset 0 is the most significant byte.
  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = off[1] ? word[15:0] : word[31:16];
    r = word;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    if (sz == 2'b01) begin
      if (off[1]) r[15:0] = wd[15:0];
      else        r[31:16] = wd[15:0];
    end else begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end
    return r;
  endfunction

  always_comb begin
    lastOffset = 2'd0;
    case (size_i)
      2'b01:   lastOffset = 2'd1;
      2'b10:   lastOffset = 2'd3;
      default: lastOffset = 2'd0;
    endcase
    lastByte   = {1'b0, addr_i} + {31'b0, lastOffset};
    outOfRange = BOUNDS_EN & (lastByte >= 33'(MEM_BYTES));
    reqErr     = (size_i == 2'b11) ||
                 ((size_i == 2'b01) && addr_i[0]) ||
                 ((size_i == 2'b10) && (addr_i[1:0] != 2'b00)) ||
                 outOfRange;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          err_d = reqErr;
          if (reqErr)                 state_d = DONE;
          else if (!we_i)             state_d = RD;
          else if (size_i == 2'b10)   state_d = WR;
          else                        state_d = RMW_RD;
        end
      end
      RD:      state_d = DONE;
      WR:      state_d = DONE;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign loadValue  = extractLoad(dm_dout_i, addr_q[1:0], size_q, sext_q);
  assign mergedWord = mergeStore(mergeWord_q, addr_q[1:0], size_q, wdata_q);

  // dm_dout is only captured in the two read states, where the memory drives it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      mergeWord_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_i) begin
        size_q  <= size_i;
        sext_q  <= sext_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_q == RD)     rdata_q     <= loadValue;
      if (state_q == RMW_RD) mergeWord_q <= dm_dout_i;
    end
  end

  always_comb begin
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE);
    err_o     = (state_q == DONE) && err_q;
    dm_rd_o   = (state_q == RD) || (state_q == RMW_RD);
    dm_wr_o   = (state_q == WR) || (state_q == RMW_WR);
    dm_cs_o   = dm_rd_o || dm_wr_o;
    dm_addr_o = {addr_q[31:2], 2'b00};
    dm_din_o  = 32'h0;
    if (state_q == WR)     dm_din_o = wdata_q;
    if (state_q == RMW_WR) dm_din_o = mergedWord;
    rdata_o   = rdata_q;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator placed between the integer datapath and the 4K×8 big-endian data memory. Accepts one load or store request at a time from the datapath, drives the data memory's chip-select/read/write strobes, and performs byte/halfword/word accesses with sign or zero extension on loads and read-modify-write merging on sub-word stores. Misaligned, reserved-size and optionally out-of-range requests are rejected with an error pulse and no memory write.

## Interface
- MEM_BYTES, 4096, data memory size in bytes; used by bounds check
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- sext  in  1  loads: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified for byte/halfword
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = request rejected
- rdata  out  32  load result, held until the next load completes
- dm_cs, dm_rd, dm_wr  out  1 each  data memory strobes
- dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dm_din  out  32  write data to memory
- dm_dout  in  32  memory read data; Hi-Z unless dm_cs&dm_rd

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE: on req=1, latch we/size/sext/addr/wdata. Error check: size=11, halfword with addr[0]=1, or word with addr[1:0]≠00 (plus bounds, see Configuration) -> DONE with err=1. Else load -> RD; word store -> WR; byte/halfword store -> RMW_RD.
- RD: dm_cs=dm_rd=1; at the clock edge, extract and extend the addressed field of dm_dout into rdata -> DONE.
- WR: dm_cs=dm_wr=1, dm_din=wdata -> DONE.
- RMW_RD: dm_cs=dm_rd=1; register dm_dout into merge word -> RMW_WR.
- RMW_WR: dm_cs=dm_wr=1, dm_din=merge word with addressed field replaced by wdata[7:0] or wdata[15:0] -> DONE.
- DONE: done=1 (err as decided) -> IDLE.
- Big-endian lanes, o=addr[1:0]: byte = word[31-8o -: 8]; halfword o=0 -> word[31:16], o=2 -> word[15:0].
- Extension: sext=1 replicates field MSB into upper bits; sext=0 fills zeros. Word loads ignore sext.
- Strobes are zero in IDLE and DONE; dm_rd and dm_wr are never high together. dm_dout is never sampled outside RD/RMW_RD.
- req while busy is ignored (not queued).
- Error requests: no strobe ever asserted; rdata unchanged.

## Timing
- Reset values: state IDLE; busy, done, err, dm_cs, dm_rd, dm_wr = 0; rdata, dm_addr, dm_din = 0.
- req accepted at edge N. Load: RD in cycle N+1, done in cycle N+2 with rdata valid. Word store: WR in N+1, done in N+2. Sub-word store: RMW_RD N+1, RMW_WR N+2, done N+3. Error: done/err in N+1.
- New req accepted earliest in the cycle after done (IDLE).
- Memory write commits on the edge ending WR/RMW_WR.
- Reset mid-operation: strobes drop immediately (asynchronous); if reset_n is low at the edge ending WR/RMW_WR, no write occurs; no done is issued for the aborted request.

## Configuration
- LSU_BOUNDS_CHECK_EN defined: any request whose last accessed byte (addr + access size − 1) ≥ MEM_BYTES is rejected with err=1 and issues no strobes.
- Not defined: no range check; dm_addr passed through unchanged; out-of-range behaviour is the memory's.

## Test plan
- Word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 -> store done at N+2 err=0; load rdata=0xDEADBEEF; memory bytes 0x10..0x13 = DE,AD,BE,EF.
- Byte load addr=0x11, sext=1, then sext=0 -> rdata=0xFFFFFFAD, then 0x000000AD.
- Byte store addr=0x12, wdata=0x00000055, then word load 0x10 -> dm_rd in N+1, dm_wr in N+2, done N+3; rdata=0xDEAD55EF.
- Halfword load addr=0x13 and word store addr=0x0E -> done in N+1 with err=1, no dm_cs asserted, memory unchanged.
- With LSU_BOUNDS_CHECK_EN: word load addr=0xFFC -> err=0; addr=0x1000 -> err=1, no strobes.
- Assert reset_n low during RMW_WR of byte store 0x77 to 0x10 -> all outputs 0 at once, no done, word 0x10 still 0xDEAD55EF; busy=0 after release.
